// File: rtl/bridge_arb.sv
// bridge_arb: round-robin arbiter that funnels NCH one-shot request channels onto one AXI-lite-style DRAM port
// Ports: clk/rst_n (async active-low); C_in_valid/C_r_wb/C_addr/C_data_w per-channel requests;
// C_out_valid/C_data_r/C_err per-channel completions; AR/R/AW/W/B DRAM handshakes, one transaction at a time.
module bridge_arb #(
    parameter int                NCH    = 2,
    parameter int                IDX_W  = 8,
    parameter int                DATA_W = 64,
    parameter int                ADDR_W = 17,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(17'h10000)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NCH-1:0]          C_in_valid,
    input  logic [NCH-1:0]          C_r_wb,
    input  logic [NCH*IDX_W-1:0]    C_addr,
    input  logic [NCH*DATA_W-1:0]   C_data_w,
    output logic [NCH-1:0]          C_out_valid,
    output logic [NCH*DATA_W-1:0]   C_data_r,
    output logic [NCH-1:0]          C_err,
    output logic                    AR_VALID,
    output logic [ADDR_W-1:0]       AR_ADDR,
    input  logic                    AR_READY,
    input  logic                    R_VALID,
    input  logic [DATA_W-1:0]       R_DATA,
    input  logic [1:0]              R_RESP,
    output logic                    R_READY,
    output logic                    AW_VALID,
    output logic [ADDR_W-1:0]       AW_ADDR,
    input  logic                    AW_READY,
    output logic                    W_VALID,
    output logic [DATA_W-1:0]       W_DATA,
    input  logic                    W_READY,
    input  logic                    B_VALID,
    input  logic [1:0]              B_RESP,
    output logic                    B_READY
);
    localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int BYTES = DATA_W / 8;

    typedef enum logic [2:0] {IDLE, AR, R, AW, W, B, DONE} state_t;

    state_t              state_q;
    logic [NCH-1:0]      pend_q, pend_d, take, fin;
    logic                rwb_q   [NCH];
    logic [IDX_W-1:0]    idx_q   [NCH];
    logic [DATA_W-1:0]   wdata_q [NCH];
    logic [PW-1:0]       ptr_q, g_q, gnt, c;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wd_q;
    logic [NCH*DATA_W-1:0] dr_q;
    logic [NCH-1:0]      ov_q, err_q;
    logic                ar_v_q, r_rdy_q, aw_v_q, w_v_q, b_rdy_q;

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        // A channel re-requesting in its own DONE cycle is accepted; set beats clear.
        assign fin[k]    = (state_q == DONE) && (g_q == PW'(k));
        assign take[k]   = C_in_valid[k] && (!pend_q[k] || fin[k]);
        assign pend_d[k] = take[k] || (pend_q[k] && !fin[k]);
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rwb_q[k]   <= 1'b0;
                idx_q[k]   <= '0;
                wdata_q[k] <= '0;
            end else if (take[k]) begin
                rwb_q[k]   <= C_r_wb[k];
                idx_q[k]   <= C_addr[k*IDX_W +: IDX_W];
                wdata_q[k] <= C_data_w[k*DATA_W +: DATA_W];
            end
        end
    end

    // Scan from the highest offset down so the lowest offset from ptr wins.
    always_comb begin
        gnt = ptr_q;
        c   = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            c = PW'((int'(ptr_q) + i) % NCH);
            if (pend_q[c]) gnt = c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend_q <= '0;
        else        pend_q <= pend_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            addr_q  <= '0;
            wd_q    <= '0;
            dr_q    <= '0;
            ov_q    <= '0;
            err_q   <= '0;
            ar_v_q  <= 1'b0;
            r_rdy_q <= 1'b0;
            aw_v_q  <= 1'b0;
            w_v_q   <= 1'b0;
            b_rdy_q <= 1'b0;
        end else begin
            ov_q  <= '0;
            err_q <= '0;
            case (state_q)
                IDLE: if (|pend_q) begin
                    g_q     <= gnt;
                    addr_q  <= BASE + ADDR_W'(32'(idx_q[gnt]) * BYTES);
                    wd_q    <= wdata_q[gnt];
                    ar_v_q  <= rwb_q[gnt];
                    aw_v_q  <= !rwb_q[gnt];
                    state_q <= rwb_q[gnt] ? AR : AW;
                end
                AR: if (AR_READY) begin
                    ar_v_q  <= 1'b0;
                    r_rdy_q <= 1'b1;
                    state_q <= R;
                end
                R: if (R_VALID) begin
                    r_rdy_q                     <= 1'b0;
                    dr_q[g_q*DATA_W +: DATA_W]  <= R_DATA;
                    ov_q[g_q]                   <= 1'b1;
                    err_q[g_q]                  <= |R_RESP;
                    state_q                     <= DONE;
                end
                AW: if (AW_READY) begin
                    aw_v_q  <= 1'b0;
                    w_v_q   <= 1'b1;
                    state_q <= W;
                end
                W: if (W_READY) begin
                    w_v_q   <= 1'b0;
                    b_rdy_q <= 1'b1;
                    state_q <= B;
                end
                B: if (B_VALID) begin
                    b_rdy_q    <= 1'b0;
                    ov_q[g_q]  <= 1'b1;
                    err_q[g_q] <= |B_RESP;
                    state_q    <= DONE;
                end
                DONE: begin
                    ptr_q   <= (g_q == PW'(NCH - 1)) ? '0 : g_q + PW'(1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign C_out_valid = ov_q;
    assign C_err       = err_q;
    assign C_data_r    = dr_q;
    assign AR_VALID    = ar_v_q;
    assign AR_ADDR     = addr_q;
    assign R_READY     = r_rdy_q;
    assign AW_VALID    = aw_v_q;
    assign AW_ADDR     = addr_q;
    assign W_VALID     = w_v_q;
    assign W_DATA      = wd_q;
    assign B_READY     = b_rdy_q;
endmodule

// File: doc/bridge_arb.md
# bridge_arb

Parametrised multi-channel successor to the single-requester bridge: NCH independent requester channels, each a one-shot C_in_valid request port, share one AXI-lite-style read/write port to the pseudo DRAM. Requests are latched per channel and granted round-robin. Exactly one DRAM transaction is in flight at a time. Each channel gets its own completion pulse, read data and response-error flag. Sits between the BEV-style front-end and pseudo_DRAM in the TESTBED.

## Interface
Parameters:
- NCH, 2: number of requester channels (≥1).
- IDX_W, 8: per-channel entry index width.
- DATA_W, 64: data word width (multiple of 8).
- ADDR_W, 17: DRAM byte-address width.
- BASE, 17'h10000: DRAM byte address of entry 0.

Ports:
- clk  in  1  the single clock; all state changes on its rising edge.
- rst_n  in  1  reset; asynchronous and active-low.
- C_in_valid  in  NCH  one-cycle request pulse per channel.
- C_r_wb  in  NCH  per channel, 1 = read, 0 = write; sampled with C_in_valid.
- C_addr  in  NCH*IDX_W  packed entry indices; channel k at [k*IDX_W +: IDX_W].
- C_data_w  in  NCH*DATA_W  packed write data.
- C_out_valid  out  NCH  one-cycle completion pulse.
- C_data_r  out  NCH*DATA_W  per-channel read data; holds until that channel's next read completes.
- C_err  out  NCH  valid with C_out_valid: DRAM response was nonzero.
- AR_VALID out 1, AR_ADDR out ADDR_W, AR_READY in 1: read-address handshake.
- R_VALID in 1, R_DATA in DATA_W, R_RESP in 2, R_READY out 1: read-data handshake.
- AW_VALID out 1, AW_ADDR out ADDR_W, AW_READY in 1: write-address handshake.
- W_VALID out 1, W_DATA out DATA_W, W_READY in 1: write-data handshake.
- B_VALID in 1, B_RESP in 2, B_READY out 1: write-response handshake.

## Operation
- Per-channel request registers hold pend, r_wb, idx and wdata.
- C_in_valid[k] with pend[k]=0 latches the request and sets pend[k].
- C_in_valid[k] with pend[k]=1 is ignored: no state change, no response.
- Address: BASE + idx*(DATA_W/8), truncated to ADDR_W bits.
- Round-robin pointer ptr starts at 0.
- Grant goes to the first pending channel found scanning ptr, ptr+1, …, modulo NCH.
- After channel g completes, ptr becomes (g+1) mod NCH.
- FSM states: IDLE, AR, R, AW, W, B, DONE.
  - IDLE: if any pend bit is set, register the grant g and go to AR (read) or AW (write). Otherwise stay.
  - AR: AR_VALID=1 with AR_ADDR; on AR_READY go to R.
  - R: R_READY=1; on R_VALID capture R_DATA into C_data_r[g] and latch err = (R_RESP!=0); go to DONE.
  - AW: AW_VALID=1 with AW_ADDR; on AW_READY go to W.
  - W: W_VALID=1 with W_DATA = wdata[g]; on W_READY go to B.
  - B: B_READY=1; on B_VALID latch err = (B_RESP!=0); go to DONE.
  - DONE: C_out_valid[g]=1 and C_err[g]=err for one cycle; clear pend[g]; update ptr; go to IDLE.
- A VALID output, once raised, holds with stable address and data until its READY is seen.
- Write completion leaves C_data_r[g] unchanged.
- C_in_valid[g] in the same cycle as DONE for g: the new request is latched, and set wins over clear.

## Timing
- Reset (async assert, sync release) clears:
  - all outputs to 0 (including C_data_r);
  - every pend bit;
  - ptr;
  - FSM state, which returns to IDLE.
- Reset mid-transaction drops that transaction. No completion pulse is issued for it.
- The pend[k] bit is visible the cycle after C_in_valid[k]. The earliest grant (IDLE) is that same cycle.
- Zero-wait DRAM read, C_in_valid at cycle 0:
  - cycle 1: IDLE;
  - cycle 2: AR;
  - cycle 3: R;
  - cycle 4: DONE, C_out_valid high.
- Zero-wait DRAM write: C_out_valid at cycle 5.
- Each DRAM wait cycle adds exactly one cycle of latency.
- Only one bit of C_out_valid is high in any cycle, and it is never high two cycles in a row.
- Combinational outputs: none. All outputs are registered or decoded directly from state.

## Test plan
- Reset: drive rst_n=0 mid-AR phase → every output 0 immediately (asynchronous), FSM in IDLE; after release, no stray C_out_valid.
- Single read, NCH=2: ch0 reads idx 8'h05 with zero-wait DRAM → AR_ADDR=17'h10028; C_out_valid=2'b01 at cycle 4; C_data_r[0] = DRAM word; C_err[0]=0.
- Single write with a 3-cycle AW_READY delay: ch1 writes idx 8'hFF, data 64'hDEAD_BEEF_0123_4567 → AW_ADDR=17'h107F8; W_DATA matches; C_out_valid=2'b10 at cycle 8.
- Fairness: ch0 and ch1 both request at cycle 0, then ch0 re-requests during its DONE cycle → order of service is ch0, ch1, ch0.
- Error and drop: B_RESP=2'b10 → C_err pulses with C_out_valid. A second C_in_valid on an already-pending channel is ignored: exactly one completion.
- NCH=4, DATA_W=32: all four channels request at once → completions in order 0,1,2,3; address stride 4; no overlapping VALID outputs.
